// File: rtl/button_pkg.sv
// Shared definitions for the button front end: gesture FSM encodings and
// default timing used by the button top level.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } press_state_t;

  localparam int LONG_CYCLES_DEF = 50_000_000;
  localparam int GAP_CYCLES_DEF  = 15_000_000;

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced press/release edge pulses into single click, double
// click and long press pulses, plus a held level while a long press lasts.
//
// state  | meaning
// IDLE   | no gesture in progress
// PRESS1 | first press down, timing toward long press
// WAIT2  | released once, waiting for a second press within the gap
// PRESS2 | second press down, double click pending on release
// HOLD   | long press recognised, waiting for release
module press_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int CNT_W       = $clog2(LONG_CYCLES > GAP_CYCLES ? LONG_CYCLES : GAP_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic p_edge,
  input  logic n_edge,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

  press_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             p_ok, n_ok, viol;
  logic             single_nxt, double_nxt, long_nxt;

  // Simultaneous edges are a protocol violation and freeze the state.
  assign viol = p_edge & n_edge;
  assign p_ok = p_edge & ~n_edge;
  assign n_ok = n_edge & ~p_edge;

  always_comb begin
    state_nxt  = state;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (p_ok) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (n_ok) begin
          state_nxt = WAIT2;
        end else if (!viol && cnt == LONG_TC) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end
      WAIT2: begin
        if (p_ok) begin
          state_nxt = PRESS2;
        end else if (!viol && cnt == GAP_TC) begin
          state_nxt  = IDLE;
          single_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (n_ok) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end else if (!viol && cnt == LONG_TC) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (n_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == PRESS1 || state == WAIT2 || state == PRESS2) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      single_click <= single_nxt;
      double_click <= double_nxt;
      long_press   <= long_nxt;
      held         <= (state_nxt == HOLD);
    end
  end

endmodule
